// File: rtl/spi_adc_responder.sv
// SPI responder for a 16-bit header + 8-bit data frame (MSB first) with a parallel-exposed byte bank.
// Define SPI_RSP_STREAM_EN for streaming mode: the address auto-increments and every further byte commits.
module spi_adc_responder #(
  parameter int         AW      = 4,
  parameter logic [7:0] CHIP_ID = 8'h93
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_t,
  output logic [8*(2**AW)-1:0]  regs_o,
  output logic                  wr_stb_o,
  output logic [AW-1:0]         wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic [15:0]           frm_ok_o,
  output logic [15:0]           frm_err_o
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_t;

  logic cs_meta_q, cs_sync_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sck_rise, sck_fall;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [14:0]     hdr_q, hdr_d;
  logic [15:0]     hdr_nx;
  logic            hdr_oor;
  logic [1:0]      unused_hdr_bits;
  logic [6:0]      data_q, data_d;
  logic [7:0]      data_nx;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            oor_q, oor_d;
  logic            byte_done_q, byte_done_d;
  logic [7:0]      miso_sh_q, miso_sh_d;
  logic            miso_q, miso_d;
  logic            miso_t_q, miso_t_d;
  logic            cmt_pend_q, cmt_pend_d;
  logic            cmt_en_q, cmt_en_d;
  logic [AW-1:0]   cmt_addr_q, cmt_addr_d;
  logic [7:0]      cmt_data_q, cmt_data_d;
  logic            wr_stb_q, wr_stb_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [15:0]     ok_q, ok_d;
  logic [15:0]     err_q, err_d;
  logic [7:0]      bank_q [1:DEPTH-1];
  logic [7:0]      bank_d [1:DEPTH-1];
  logic [8*DEPTH-1:0] bank_flat;

  // Byte 0 of the flat view is the chip ID, so address 0 needs no special case here.
  function automatic logic [7:0] read_byte(input logic [8*DEPTH-1:0] flat,
                                           input logic [AW-1:0] a, input logic oor);
    read_byte = oor ? 8'h00 : flat[{a, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      sck_meta_q  <= 1'b1;
      sck_sync_q  <= 1'b1;
      sck_prev_q  <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= spi_cs_i;
      cs_sync_q   <= cs_meta_q;
      sck_meta_q  <= spi_clk_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise        = sck_sync_q & ~sck_prev_q;
  assign sck_fall        = ~sck_sync_q & sck_prev_q;
  assign hdr_nx          = {hdr_q, mosi_sync_q};
  assign data_nx         = {data_q, mosi_sync_q};
  assign hdr_oor         = (hdr_nx[12:0] >> AW) != 13'd0;
  assign unused_hdr_bits = hdr_nx[14:13];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    data_d      = data_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    oor_d       = oor_q;
    byte_done_d = byte_done_q;
    miso_sh_d   = miso_sh_q;
    miso_d      = miso_q;
    miso_t_d    = miso_t_q;
    cmt_pend_d  = 1'b0;
    cmt_en_d    = cmt_en_q;
    cmt_addr_d  = cmt_addr_q;
    cmt_data_d  = cmt_data_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ok_d        = ok_q;
    err_d       = err_q;
    bank_d      = bank_q;

    // A write is applied one cycle after its last data bit was sampled.
    if (cmt_pend_q) begin
      ok_d = ok_q + 16'd1;
      if (cmt_en_q) begin
        bank_d[cmt_addr_q] = cmt_data_q;
        wr_stb_d           = 1'b1;
        wr_addr_d          = cmt_addr_q;
        wr_data_d          = cmt_data_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d       = 4'd0;
        byte_done_d = 1'b0;
        miso_t_d    = 1'b1;
        if (!cs_sync_q) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (cs_sync_q) begin
          state_d = ST_IDLE;
          if (cnt_q != 4'd0) err_d = err_q + 16'd1;
        end else if (sck_rise) begin
          hdr_d = hdr_nx[14:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d   = ST_DATA;
            cnt_d     = 4'd0;
            rd_d      = hdr_nx[15];
            addr_d    = hdr_nx[AW-1:0];
            oor_d     = hdr_oor;
            miso_sh_d = read_byte(bank_flat, hdr_nx[AW-1:0], hdr_oor);
          end
        end
      end
      ST_DATA: begin
        // A clean stop is only possible on a byte boundary after at least one full byte.
        if (cs_sync_q) begin
          state_d = ST_IDLE;
          if (cnt_q != 4'd0 || !byte_done_q) err_d = err_q + 16'd1;
        end else begin
          if (sck_fall && rd_q) begin
            miso_t_d  = 1'b0;
            miso_d    = miso_sh_q[7];
            miso_sh_d = {miso_sh_q[6:0], 1'b0};
          end
          if (sck_rise) begin
            data_d = data_nx[6:0];
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d       = 4'd0;
              byte_done_d = 1'b1;
              if (rd_q) begin
                ok_d = ok_d + 16'd1;
              end else begin
                cmt_pend_d = 1'b1;
                cmt_en_d   = !oor_q && (addr_q != '0);
                cmt_addr_d = addr_q;
                cmt_data_d = data_nx;
              end
`ifdef SPI_RSP_STREAM_EN
              addr_d = addr_q + 1'b1;
              if (rd_q) miso_sh_d = read_byte(bank_flat, addr_q + 1'b1, oor_q);
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end
      ST_DONE: begin
        if (cs_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      oor_q       <= 1'b0;
      byte_done_q <= 1'b0;
      miso_sh_q   <= '0;
      miso_q      <= 1'b0;
      miso_t_q    <= 1'b1;
      cmt_pend_q  <= 1'b0;
      cmt_en_q    <= 1'b0;
      cmt_addr_q  <= '0;
      cmt_data_q  <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ok_q        <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      oor_q       <= oor_d;
      byte_done_q <= byte_done_d;
      miso_sh_q   <= miso_sh_d;
      miso_q      <= miso_d;
      miso_t_q    <= miso_t_d;
      cmt_pend_q  <= cmt_pend_d;
      cmt_en_q    <= cmt_en_d;
      cmt_addr_q  <= cmt_addr_d;
      cmt_data_q  <= cmt_data_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
    if (gi == 0) begin : g_id
      assign bank_flat[7:0] = CHIP_ID;
    end else begin : g_reg
      always_ff @(posedge clk_i) begin
        if (rst_i) bank_q[gi] <= 8'h00;
        else       bank_q[gi] <= bank_d[gi];
      end
      assign bank_flat[8*gi +: 8] = bank_q[gi];
    end
  end

  assign regs_o     = bank_flat;
  assign spi_miso_o = miso_q;
  assign spi_miso_t = miso_t_q;
  assign wr_stb_o   = wr_stb_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign frm_ok_o   = ok_q;
  assign frm_err_o  = err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Scoreboard bench for spi_adc_responder: a frame-level model predicts writes, read bytes and counters.
module tb_spi_adc_responder;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] CID   = 8'h93;
  localparam int         HALF  = 8;

  logic clk, rst_i, spi_cs_i, spi_clk_i, spi_mosi_i;
  logic spi_miso_o, spi_miso_t, wr_stb_o;
  logic [8*DEPTH-1:0] regs_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [15:0] frm_ok_o, frm_err_o;

  spi_adc_responder #(.AW(AW), .CHIP_ID(CID)) dut (
    .clk_i(clk), .rst_i(rst_i), .spi_cs_i(spi_cs_i), .spi_clk_i(spi_clk_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
    .regs_o(regs_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .frm_ok_o(frm_ok_o), .frm_err_o(frm_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic [7:0]  mdl_bank [DEPTH];
  logic [15:0] mdl_ok, mdl_err;
  wr_t         exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  obs_rd_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_bank[i] = 8'h00;
    mdl_ok  = 16'd0;
    mdl_err = 16'd0;
  endfunction

  // Returns how many read bytes the master should observe for this frame.
  function automatic int model_frame(input logic [15:0] hdr, input logic [31:0] dat, input int nbits);
    int nfull;
    bit partial, oor, rd;
    int base, a;
    logic [7:0] b;
    if (nbits == 0) return 0;
    if (nbits < 24) begin
      mdl_err = mdl_err + 16'd1;
      return 0;
    end
    rd   = hdr[15];
    base = int'(hdr[3:0]);
    oor  = (hdr[12:4] != 9'd0);
`ifdef SPI_RSP_STREAM_EN
    nfull   = (nbits - 16) / 8;
    partial = ((nbits - 16) % 8) != 0;
`else
    nfull   = 1;
    partial = 1'b0;
`endif
    for (int k = 0; k < nfull; k++) begin
      a = (base + k) % DEPTH;
      b = dat[31 - 8*k -: 8];
      if (rd) begin
        exp_rd_q.push_back(oor ? 8'h00 : (a == 0 ? CID : mdl_bank[a]));
      end else if (!oor && a != 0) begin
        mdl_bank[a] = b;
        exp_wr_q.push_back('{a: a[AW-1:0], d: b});
      end
      mdl_ok = mdl_ok + 16'd1;
    end
    if (partial) mdl_err = mdl_err + 16'd1;
    return rd ? nfull : 0;
  endfunction

  // Monitor: compares every DUT write strobe and every captured read byte against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    logic [7:0] o, r;
    if (wr_stb_o === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_wr_stb", {wr_addr_o, wr_data_o}, 128'h0);
      end else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", wr_addr_o, e.a);
        chk("wr_data", wr_data_o, e.d);
        chk("regs_at_wr", regs_o[{e.a, 3'b000} +: 8], e.d);
      end
    end
    if (obs_rd_q.size() > 0) begin
      o = obs_rd_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        chk("unexpected_rd_byte", o, 128'h1ff);
      end else begin
        r = exp_rd_q.pop_front();
        chk("rd_byte", o, r);
      end
    end
  end

  task automatic half_sck();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [47:0] bits, input int nbits, input int ncap, input int rst_bit,
                          output logic [31:0] cap, output logic t_low);
    bit aborted = 1'b0;
    cap   = '0;
    t_low = 1'b1;
    @(negedge clk);
    spi_cs_i   = 1'b0;
    spi_mosi_i = bits[47];
    half_sck();
    for (int i = 0; i < nbits; i++) begin
      spi_clk_i  = 1'b0;
      spi_mosi_i = bits[47 - i];
      if (i == rst_bit) begin
        rst_i     = 1'b1;
        spi_cs_i  = 1'b1;
        spi_clk_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i   = 1'b0;
        aborted = 1'b1;
        break;
      end
      half_sck();
      spi_clk_i = 1'b1;
      if (i >= 16 && i < 16 + 8*ncap) begin
        cap   = {cap[30:0], spi_miso_o};
        t_low = t_low & (spi_miso_t == 1'b0);
      end
      half_sck();
    end
    if (!aborted) spi_cs_i = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] hdr, input logic [31:0] dat, input int nbits, input int rst_bit);
    int nrd;
    logic [31:0] cap;
    logic tl;
    logic [8*DEPTH-1:0] exp_regs;
    nrd = (rst_bit < 0) ? model_frame(hdr, dat, nbits) : 0;
    spi_xfer({hdr, dat}, nbits, nrd, rst_bit, cap, tl);
    if (rst_bit >= 0) model_reset();
    for (int k = 0; k < nrd; k++) obs_rd_q.push_back(cap[8*(nrd-1-k) +: 8]);
    repeat (6) @(negedge clk);
    exp_regs[7:0] = CID;
    for (int a = 1; a < DEPTH; a++) exp_regs[8*a +: 8] = mdl_bank[a];
    chk("frm_ok", frm_ok_o, mdl_ok);
    chk("frm_err", frm_err_o, mdl_err);
    chk("regs", regs_o, exp_regs);
    if (nrd > 0) begin
      chk("miso_t_data", tl, 1'b1);
      chk("miso_t_idle", spi_miso_t, 1'b1);
    end
    if (rst_bit >= 0) begin
      chk("rst_miso_t", spi_miso_t, 1'b1);
      chk("rst_miso_o", spi_miso_o, 1'b0);
      chk("rst_wr_addr", wr_addr_o, 4'h0);
      chk("rst_wr_data", wr_data_o, 8'h00);
    end
    $display("frame hdr=%04h dat=%08h nbits=%0d rst_bit=%0d ok=%0d err=%0d",
             hdr, dat, nbits, rst_bit, frm_ok_o, frm_err_o);
  endtask

  initial begin
    logic [15:0] hdr;
    logic [31:0] dat;
    int nb;
    rst_i      = 1'b1;
    spi_cs_i   = 1'b1;
    spi_clk_i  = 1'b1;
    spi_mosi_i = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_regs", regs_o, {120'h0, CID});
    chk("reset_ok", frm_ok_o, 16'h0);
    chk("reset_err", frm_err_o, 16'h0);
    chk("reset_miso_t", spi_miso_t, 1'b1);
    chk("reset_miso_o", spi_miso_o, 1'b0);
    chk("reset_wr_stb", wr_stb_o, 1'b0);

    frame(16'h0005, 32'hA500_0000, 24, -1);
    chk("first_wr_addr", wr_addr_o, 4'h5);
    chk("first_wr_byte5", regs_o[47:40], 8'hA5);
    frame(16'h8005, 32'h0, 24, -1);
    frame(16'h8000, 32'h0, 24, -1);
    frame(16'h0000, 32'h5A00_0000, 24, -1);
    frame(16'h0040, 32'h7700_0000, 24, -1);
    frame(16'h8040, 32'h0, 24, -1);
    frame(16'h0003, 32'h0, 12, -1);
    chk("abort_err", frm_err_o, 16'd1);
    frame(16'h0003, 32'h3C00_0000, 24, -1);
    frame(16'h0000, 32'h0, 0, -1);
    frame(16'h0009, 32'hC300_0000, 24, 20);
`ifdef SPI_RSP_STREAM_EN
    frame(16'h000E, 32'h1122_3300, 40, -1);
    chk("stream_ok", frm_ok_o, 16'd3);
    frame(16'h800E, 32'h0, 44, -1);
`else
    frame(16'h0007, 32'hE1D2_0000, 32, -1);
    chk("extra_bits_ok", frm_ok_o, 16'd1);
`endif

    for (int t = 0; t < 30; t++) begin
      hdr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) hdr[12:4] = 9'd0;
      dat = $urandom;
      if ($urandom_range(0, 9) == 0) nb = $urandom_range(0, 23);
`ifdef SPI_RSP_STREAM_EN
      else nb = 24 + $urandom_range(0, 24);
`else
      else nb = 24 + $urandom_range(0, 8);
`endif
      frame(hdr, dat, nb, -1);
    end

    repeat (4) @(negedge clk);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
